// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants, field positions and state type for the fetch stage
package fetch_pkg;
  localparam int DEPTH = 128;
  localparam int ADDR_W = 7;
  localparam int INSTR_W = 12;
  localparam int FIELD_W = 3;
  localparam logic [INSTR_W-1:0] NOP_WORD = 12'h000;
  localparam logic [INSTR_W-1:0] HALT_WORD = 12'hFFF;
  localparam int OP_LSB = 9;
  localparam int DEST_LSB = 6;
  localparam int IN1_LSB = 3;
  localparam int IN2_LSB = 0;
  typedef enum logic [1:0] {IDLE, RUN, DONE} fetch_state_t;
endpackage

// File: rtl/prog_store.sv
// prog_store: 128x12 program store, synchronous write, asynchronous read, no reset
module prog_store
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);
  logic [INSTR_W-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end
  assign rdata = mem[raddr];
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, run FSM and registered instruction issue feeding pipelined_processor
module instr_fetch_unit
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load_en,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_flag,
  input  logic [ADDR_W-1:0]  branch_out,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instruction,
  output logic [FIELD_W-1:0] opcode,
  output logic [FIELD_W-1:0] dest_addr,
  output logic [FIELD_W-1:0] branch_addr,
  output logic [FIELD_W-1:0] in_addr1,
  output logic [FIELD_W-1:0] in_addr2,
  output logic [ADDR_W-1:0]  pc_out,
  output logic               busy
);
  fetch_state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d, rdata;
  logic valid_q, valid_d;
  prog_store u_store (
    .clk  (clk),
    .we   (load_en && state_q == IDLE),
    .waddr(load_addr),
    .wdata(load_data),
    .raddr(pc_q),
    .rdata(rdata)
  );
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: if (start) begin
        state_d = RUN;
        pc_d = '0;
      end
      RUN: if (branch_flag) begin
        pc_d = branch_out;
        instr_d = NOP_WORD;
        valid_d = 1'b0;
      end else if (!stall) begin
        instr_d = rdata;
        valid_d = 1'b1;
        pc_d = (rdata == HALT_WORD) ? pc_q : pc_q + 1'b1;
        if (rdata == HALT_WORD || pc_q == ADDR_W'(DEPTH - 1)) state_d = DONE;
      end
      DONE: begin
        valid_d = 1'b0;
        if (start) begin
          state_d = RUN;
          pc_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign instr_valid = valid_q;
  assign instruction = instr_q;
  assign opcode = instr_q[OP_LSB +: FIELD_W];
  assign dest_addr = instr_q[DEST_LSB +: FIELD_W];
  assign branch_addr = instr_q[DEST_LSB +: FIELD_W];
  assign in_addr1 = instr_q[IN1_LSB +: FIELD_W];
  assign in_addr2 = instr_q[IN2_LSB +: FIELD_W];
  assign pc_out = pc_q;
  assign busy = state_q == RUN;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed checks of load, run, halt, branch, stall, end of store and reset
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic rst_n, load_en, start, stall, branch_flag;
  logic [6:0] load_addr, branch_out, pc_out;
  logic [11:0] load_data, instruction;
  logic instr_valid, busy;
  logic [2:0] opcode, dest_addr, branch_addr, in_addr1, in_addr2;
  int n_chk = 0;
  int n_pass = 0;
  instr_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .stall(stall), .branch_flag(branch_flag),
    .branch_out(branch_out), .instr_valid(instr_valid), .instruction(instruction),
    .opcode(opcode), .dest_addr(dest_addr), .branch_addr(branch_addr),
    .in_addr1(in_addr1), .in_addr2(in_addr2), .pc_out(pc_out), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic expect_out(input string tag, input logic v, input logic [11:0] ins, input logic [6:0] pc, input logic b);
    check({tag, ".valid"}, instr_valid, v);
    check({tag, ".instr"}, instruction, ins);
    check({tag, ".pc"}, pc_out, pc);
    check({tag, ".busy"}, busy, b);
  endtask
  task automatic load(input logic [6:0] a, input logic [11:0] d);
    load_en = 1'b1;
    load_addr = a;
    load_data = d;
    tick();
    load_en = 1'b0;
  endtask
  task automatic pulse_start;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  initial begin
    rst_n = 1'b0; load_en = 1'b0; start = 1'b0; stall = 1'b0; branch_flag = 1'b0;
    load_addr = '0; load_data = '0; branch_out = '0;
    tick();
    tick();
    expect_out("reset", 1'b0, 12'h000, 7'd0, 1'b0);
    check("reset.fields", {opcode, dest_addr, branch_addr, in_addr1, in_addr2}, 15'd0);
    rst_n = 1'b1;
    for (int i = 4; i < 128; i++) load(7'(i), 12'h200 + 12'(i));
    load(7'd0, 12'h123);
    load(7'd1, 12'h456);
    load(7'd2, 12'h789);
    load(7'd3, 12'hFFF);
    pulse_start();
    expect_out("start", 1'b0, 12'h000, 7'd0, 1'b1);
    tick(); expect_out("run0", 1'b1, 12'h123, 7'd1, 1'b1);
    tick(); expect_out("run1", 1'b1, 12'h456, 7'd2, 1'b1);
    check("op", opcode, 3'd2);
    check("dest", dest_addr, 3'd1);
    check("baddr", branch_addr, 3'd1);
    check("in1", in_addr1, 3'd2);
    check("in2", in_addr2, 3'd6);
    tick(); expect_out("run2", 1'b1, 12'h789, 7'd3, 1'b1);
    tick(); expect_out("halt", 1'b1, 12'hFFF, 7'd3, 1'b0);
    tick(); expect_out("done", 1'b0, 12'hFFF, 7'd3, 1'b0);
    branch_flag = 1'b1; branch_out = 7'd50;
    tick(); expect_out("done_br", 1'b0, 12'hFFF, 7'd3, 1'b0);
    branch_flag = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_out("rst2", 1'b0, 12'h000, 7'd0, 1'b0);
    load(7'd3, 12'h203);
    pulse_start();
    tick(); expect_out("b_run0", 1'b1, 12'h123, 7'd1, 1'b1);
    tick(); expect_out("b_run1", 1'b1, 12'h456, 7'd2, 1'b1);
    branch_flag = 1'b1; branch_out = 7'd10;
    tick(); expect_out("bubble", 1'b0, 12'h000, 7'd10, 1'b1);
    branch_flag = 1'b0;
    tick(); expect_out("target", 1'b1, 12'h20A, 7'd11, 1'b1);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(); expect_out("stall", 1'b1, 12'h20A, 7'd11, 1'b1);
    end
    branch_flag = 1'b1; branch_out = 7'd20;
    tick(); expect_out("stall_br", 1'b0, 12'h000, 7'd20, 1'b1);
    branch_flag = 1'b0; stall = 1'b0;
    tick(); expect_out("stall_tgt", 1'b1, 12'h214, 7'd21, 1'b1);
    load_en = 1'b1; load_addr = 7'd0; load_data = 12'hBAD;
    tick(); expect_out("run_load", 1'b1, 12'h215, 7'd22, 1'b1);
    load_en = 1'b0;
    branch_flag = 1'b1; branch_out = 7'd125;
    tick(); expect_out("to125", 1'b0, 12'h000, 7'd125, 1'b1);
    branch_flag = 1'b0;
    tick(); expect_out("f125", 1'b1, 12'h27D, 7'd126, 1'b1);
    tick(); expect_out("f126", 1'b1, 12'h27E, 7'd127, 1'b1);
    tick(); expect_out("f127", 1'b1, 12'h27F, 7'd0, 1'b0);
    tick(); expect_out("eos_done", 1'b0, 12'h27F, 7'd0, 1'b0);
    pulse_start();
    expect_out("restart", 1'b0, 12'h27F, 7'd0, 1'b1);
    tick(); expect_out("rerun0", 1'b1, 12'h123, 7'd1, 1'b1);
    tick(); expect_out("rerun1", 1'b1, 12'h456, 7'd2, 1'b1);
    tick(); expect_out("rerun2", 1'b1, 12'h789, 7'd3, 1'b1);
    tick(); expect_out("rerun3", 1'b1, 12'h203, 7'd4, 1'b1);
    tick(); expect_out("rerun4", 1'b1, 12'h204, 7'd5, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    expect_out("rst_mid", 1'b0, 12'h000, 7'd0, 1'b0);
    check("rst_mid.fields", {opcode, dest_addr, branch_addr, in_addr1, in_addr2}, 15'd0);
    pulse_start();
    tick(); expect_out("post_rst", 1'b1, 12'h123, 7'd1, 1'b1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage that sits directly upstream of `pipelined_processor`. It holds a 128-entry × 12-bit program store and owns the program counter. Each cycle it issues one registered instruction, split into the processor's 3-bit fields, and redirects on the processor's `branch_flag`/`branch_out`. It also supports stall, halt, and a load port for filling the program store before a run.

## Interface
- `DEPTH`, 128, program store entries
- `ADDR_W`, 7, PC / store address width
- `INSTR_W`, 12, instruction width
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  synchronous, active-low reset
- `load_en`  in  1  write enable for the program store; honoured only in IDLE
- `load_addr`  in  7  program store write address
- `load_data`  in  12  program store write data
- `start`  in  1  begin a run from PC 0; honoured in IDLE and DONE
- `stall`  in  1  downstream not ready; hold PC and outputs
- `branch_flag`  in  1  redirect request from the processor
- `branch_out`  in  7  branch target address
- `instr_valid`  out  1  `instruction` and its fields are valid this cycle
- `instruction`  out  12  registered fetched word
- `opcode`  out  3  `instruction[11:9]`
- `dest_addr`  out  3  `instruction[8:6]`
- `branch_addr`  out  3  `instruction[8:6]` (shares the dest field; branches write no register)
- `in_addr1`  out  3  `instruction[5:3]`
- `in_addr2`  out  3  `instruction[2:0]`
- `pc_out`  out  7  current PC, the address of the next fetch
- `busy`  out  1  high in RUN

## Operation
- **States:** IDLE, RUN, DONE. Reset enters IDLE.
- **IDLE**
  - `load_en` writes `load_data` to `mem[load_addr]`.
  - `start` → RUN, PC ← 0.
- **RUN, evaluated each edge in priority order:**
  1. `branch_flag`: PC ← `branch_out`, instruction ← NOP (12'h000), `instr_valid` ← 0. Branch overrides `stall`.
  2. `stall`: PC, `instruction` and `instr_valid` hold.
  3. Otherwise: instruction ← `mem[PC]`, `instr_valid` ← 1, PC ← PC+1.
- **HALT word:** fetching 12'hFFF issues it with valid=1, then → DONE. PC is not incremented.
- **End of store:** fetching address 127 issues the word, then → DONE. PC wraps to 0; there is no run-on past the store.
- **DONE**
  - `instr_valid` ← 0; `instruction` keeps its last value.
  - `start` → RUN, PC ← 0.
- **Ignored inputs:**
  - `load_en` outside IDLE.
  - `start` in RUN.
  - `branch_flag` outside RUN.
- **Reset**
  - Clears PC and all outputs; state → IDLE.
  - Program store contents are NOT reset. Reset mid-run preserves the loaded program.
- Field outputs are pure combinational slices of the `instruction` register.

## Timing
- **Reset values:** `instr_valid`=0, `instruction`=12'h000, all fields=0, `pc_out`=0, `busy`=0.
- **Start latency:**
  - `start` sampled at edge t → RUN at t.
  - `mem[0]` valid after edge t+1.
  - Thereafter one instruction per unstalled cycle.
- **Branch:** `branch_flag` sampled at edge e → one bubble (valid=0) after e → `mem[branch_out]` valid after e+1.
- **Stall:** a stall cycle produces no change. The held instruction stays valid and is consumed once `stall` drops.
- **Load:** store write takes effect at the edge. Load followed immediately by `start` is legal; fetch sees the new data.
- **Simultaneous events:**
  - `branch_flag` + `stall`: branch wins.
  - Branch in the same cycle as fetch of address 127 or HALT: branch wins; stay in RUN.

## Structure
- Shared package `fetch_pkg`:
  - constants `ADDR_W`, `INSTR_W`, `NOP_WORD`=12'h000, `HALT_WORD`=12'hFFF;
  - field slice positions;
  - state enum `fetch_state_t` {IDLE, RUN, DONE}.
- One sub-module: `prog_store`. It is a single-port-write / async-read 128×12 array, with the write port gated by IDLE.
- The FSM, PC and output register stay in `instr_fetch_unit`.

## Test plan
- **Load and run:** load `mem[0..3]` = 12'h123, 12'h456, 12'h789, 12'hFFF; pulse `start`.
  - Required: valid words 123, 456, 789, FFF on four consecutive cycles; then DONE, `busy`=0.
  - Required fields for 12'h456: `opcode`=2, `dest_addr`=1, `in_addr1`=2, `in_addr2`=6.
- **Branch:** in RUN at PC 2, assert `branch_flag` with `branch_out`=10 for one cycle.
  - Required: one cycle valid=0, instruction=000; then `mem[10]`; `pc_out` then reads 11.
- **Stall and branch:** hold `stall` for 3 cycles mid-run, then assert `branch_flag` with `stall` still high.
  - Required: instruction and PC frozen for 3 cycles; branch taken on the next edge regardless of stall.
- **End of store:** program with no HALT, run to the end.
  - Required: after issuing `mem[127]`, state DONE, `pc_out`=0, `instr_valid`=0.
  - Required: a second `start` reruns from `mem[0]`.
- **Reset mid-run:** drop `rst_n` for one edge at PC 5.
  - Required: all outputs at reset values, state IDLE.
  - Required: `start` then refetches the original `mem[0]`, showing the store was preserved.
- **Ignored load:** `load_en` during RUN at address 0.
  - Required: `mem[0]` unchanged, confirmed on the next run.
